// File: rtl/mips_pkg.sv
// Opcode encodings and access sizes shared by the decoder, hazard unit and M-stage data memory.
// Nothing in this file is sequential.
package mips_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD
    } size_e;

endpackage

// File: rtl/m_stage_dmem_load_extend.sv
// Load lane select and sign/zero extension of a memory word.
// Latency: combinational. Backpressure: none.
module load_extend
    import mips_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  size_e       size_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{addr_i, 3'b000} +: 8];
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            BYTE:    data_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
            HALF:    data_o = {{16{sign_i & half_sel[15]}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/m_stage_dmem.sv
// M-stage data memory: decodes loads/stores, byte-lane writes, extended load data (ALIGN_CHECK_EN adds misalignment faults).
// Latency: LATENCY cycles per access; store commits on the completion edge. Backpressure: stall_M holds the pipeline.
module m_stage_dmem
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 3072,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_M,
    input  logic [31:0] PC_M,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        stall_M,
    output logic        adel_M,
    output logic        ades_M
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            is_load, is_store, sign_ext, misal, acc, done;
    size_e           size;
    logic [3:0]      be;
    logic [31:0]     wlane, ext_data;
    logic [AW-1:0]   idx;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sign_ext = 1'b0;
        size     = WORD;
        case (Instr_M[31:26])
            OP_LW:  begin is_load = 1'b1; size = WORD; end
            OP_LH:  begin is_load = 1'b1; size = HALF; sign_ext = 1'b1; end
            OP_LHU: begin is_load = 1'b1; size = HALF; end
            OP_LB:  begin is_load = 1'b1; size = BYTE; sign_ext = 1'b1; end
            OP_LBU: begin is_load = 1'b1; size = BYTE; end
            OP_SW:  begin is_store = 1'b1; size = WORD; end
            OP_SH:  begin is_store = 1'b1; size = HALF; end
            OP_SB:  begin is_store = 1'b1; size = BYTE; end
            default: ;
        endcase
    end

`ifdef ALIGN_CHECK_EN
    assign misal  = (is_load | is_store) &
                    (((size == WORD) && (ALUOutM[1:0] != 2'b00)) ||
                     ((size == HALF) && ALUOutM[0]));
`else
    assign misal  = 1'b0;
`endif
    assign adel_M = is_load & misal;
    assign ades_M = is_store & misal;

    // Faulting accesses never enter the FSM, so they finish in their first cycle.
    assign acc     = (is_load | is_store) & ~misal;
    assign done    = (LATENCY == 1) || ((state_q == WAIT) && (cnt_q == LAST));
    assign stall_M = reset & acc & ~done;

    // Word index wraps modulo the (not necessarily power-of-two) depth.
    assign idx = AW'(32'(ALUOutM[AW+1:2]) % DEPTH_WORDS);

    always_comb begin
        case (size)
            BYTE: begin
                be    = 4'b0001 << ALUOutM[1:0];
                wlane = {4{WriteDataM[7:0]}};
            end
            HALF: begin
                be    = ALUOutM[1] ? 4'b1100 : 4'b0011;
                wlane = {2{WriteDataM[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = WriteDataM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (acc && !done) begin
                    state_q <= WAIT;
                    cnt_q   <= CW'(1);
                end
                WAIT: if (cnt_q == LAST) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q   <= cnt_q + 1'b1;
                end
            endcase
        end
    end

    // Array has no reset so contents survive it; reset only cancels a pending write.
    always_ff @(posedge clk) begin
        if (reset && is_store && acc && done) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    load_extend u_load_extend (
        .word_i (mem_q[idx]),
        .addr_i (ALUOutM[1:0]),
        .size_i (size),
        .sign_i (sign_ext),
        .data_o (ext_data)
    );

    assign ReadDataM = (is_load && !misal) ? ext_data : 32'h0;

    logic unused_ok;
    assign unused_ok = ^{PC_M, ALUOutM[31:AW+2], Instr_M[25:0]};

endmodule
